// File: rtl/seg7_decode_monitor_if.sv
// Snapshot handshake between the 7-segment readback monitor and its consumer.
// Member names match the original flat port names so existing consumers map one-to-one.
interface seg7_decode_monitor_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] oDIG;
    logic [NUM_DIGITS-1:0]   oDOT;
    logic [NUM_DIGITS-1:0]   oERR;
    logic                    oVALID;
    logic                    iREADY;

    modport master (
        output oDIG,
        output oDOT,
        output oERR,
        output oVALID,
        input  iREADY
    );

    modport slave (
        input  oDIG,
        input  oDOT,
        input  oERR,
        input  oVALID,
        output iREADY
    );
endinterface

// File: rtl/seg7_decode_monitor.sv
// Readback monitor for active-low HEX segment buses: waits for a stable pattern,
// decodes each lane to hex plus dot, and offers the snapshot over valid/ready.
module seg7_decode_monitor #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [8*NUM_DIGITS-1:0] iSEG,
    seg7_decode_monitor_if.master   snap,
    output logic                    oDROP,
    output logic [15:0]             oCOUNT
);
    localparam int unsigned   W       = 8 * NUM_DIGITS;
    localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_e;

    state_e                  state_q, state_d;
    logic [W-1:0]            s_q, s_d, last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d, dec_dig;
    logic [NUM_DIGITS-1:0]   dot_q, dot_d, err_q, err_d, dec_err, dec_dot;
    logic                    valid_q, valid_d, drop_q, drop_d;
    logic [15:0]             count_q, count_d;
    logic                    stable, newpat;

    // Returns {err, digit}; anything outside the encoder table is flagged as an error.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h18:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        dec_dig = '0;
        dec_err = '0;
        dec_dot = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            {dec_err[k], dec_dig[4*k +: 4]} = decode(s_q[8*k +: 7]);
            dec_dot[k] = s_q[8*k+7];
        end
    end

    assign stable = (cnt_q == CNT_MAX);
    assign newpat = stable && (s_q != last_q);

    always_comb begin
        s_d     = iSEG;
        cnt_d   = cnt_q;
        state_d = state_q;
        last_d  = last_q;
        dig_d   = dig_q;
        dot_d   = dot_q;
        err_d   = err_q;
        valid_d = valid_q;
        count_d = count_q;
        drop_d  = drop_q;

        if (iSEG != s_q) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (newpat) begin
                    dig_d   = dec_dig;
                    err_d   = dec_err;
                    dot_d   = dec_dot;
                    last_d  = s_q;
                    valid_d = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (snap.iREADY) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new pattern is about to become stable while the consumer still holds the old one.
        if ((state_q == PEND) && (cnt_q == CNT_PRE) && (iSEG == s_q) && (s_q != last_q)) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            s_q     <= '1;
            last_q  <= '1;
            cnt_q   <= '0;
            dig_q   <= '0;
            dot_q   <= '1;
            err_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            dot_q   <= dot_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            count_q <= count_d;
        end
    end

    assign snap.oDIG   = dig_q;
    assign snap.oDOT   = dot_q;
    assign snap.oERR   = err_q;
    assign snap.oVALID = valid_q;
    assign oDROP       = drop_q;
    assign oCOUNT      = count_q;
endmodule
